// File: rtl/usb4_enc_pkg.sv
// Shared encodings, frame lengths and control types for the lane encoder datapath.
// No logic; no latency; no flow control.
// Imported by lane_tx_serializer and lane_shift_unit.
package usb4_enc_pkg;

    localparam logic [1:0] GEN4 = 2'd0;
    localparam logic [1:0] GEN3 = 2'd1;
    localparam logic [1:0] GEN2 = 2'd2;

    localparam int FRAME_LEN_GEN4 = 8;
    localparam int FRAME_LEN_GEN3 = 132;
    localparam int FRAME_LEN_GEN2 = 66;
    localparam int LEN_W          = 8;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    typedef struct packed {
        logic             full;
        logic [LEN_W-1:0] len;
    } hold_ctl_t;

    function automatic logic gen_supported(input logic [1:0] gen);
        return (gen == GEN4) || (gen == GEN3) || (gen == GEN2);
    endfunction

    function automatic logic [LEN_W-1:0] frame_len_of(input logic [1:0] gen);
        case (gen)
            GEN4:    return LEN_W'(FRAME_LEN_GEN4);
            GEN3:    return LEN_W'(FRAME_LEN_GEN3);
            GEN2:    return LEN_W'(FRAME_LEN_GEN2);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/lane_shift_unit.sv
// Per-lane shift register plus one-deep hold buffer, driven by shared strobes (SER_MSB_FIRST_EN: MSB first).
// Latency: a load shows bit 0 (or bit L-1) on tx_bit the following cycle.
// Backpressure: none locally; the controller decides when hold may be overwritten.
module lane_shift_unit
    import usb4_enc_pkg::*;
#(
    parameter int WORD_W = 132
`ifdef SER_MSB_FIRST_EN
    ,
    parameter int CNT_W  = 8
`endif
) (
    input  logic              enc_clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load_word,
    input  logic              load_hold,
    input  logic              shift,
    input  logic              capture,
    input  logic              go_idle,
`ifdef SER_MSB_FIRST_EN
    input  logic [CNT_W-1:0]  load_len,
    input  logic [CNT_W-1:0]  cur_len,
`endif
    input  logic [WORD_W-1:0] word,
    output logic              tx_bit
);

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] hold_dat;
    logic [WORD_W-1:0] src;

    assign src = load_hold ? hold_dat : word;

    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            hold_dat <= '0;
            tx_bit   <= 1'b0;
        end else if (clr) begin
            shreg    <= '0;
            hold_dat <= '0;
            tx_bit   <= 1'b0;
        end else begin
            // Capture and hold->shift can coincide; the load sees the old hold contents.
            if (capture) begin
                hold_dat <= word;
            end
            if (load_word || load_hold) begin
`ifdef SER_MSB_FIRST_EN
                tx_bit <= src[load_len - CNT_W'(1)];
                shreg  <= src << 1;
`else
                tx_bit <= src[0];
                shreg  <= src >> 1;
`endif
            end else if (shift) begin
`ifdef SER_MSB_FIRST_EN
                tx_bit <= shreg[cur_len - CNT_W'(1)];
                shreg  <= shreg << 1;
`else
                tx_bit <= shreg[0];
                shreg  <= shreg >> 1;
`endif
            end else if (go_idle) begin
                tx_bit <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lane_tx_serializer.sv
// Two-lane bit serializer with shared control and one-deep hold per lane (SER_MSB_FIRST_EN selects MSB-first order).
// Latency: first serial bit one enc_clk after word_valid; back-to-back frames have no gap bit.
// Backpressure: ready = hold buffer empty; a word arriving with hold full mid-frame is dropped and sets sticky overflow.
module lane_tx_serializer
    import usb4_enc_pkg::*;
#(
    parameter int WORD_W = 132,
    parameter int CNT_W  = 8
) (
    input  logic              enc_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        gen_speed,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] lane_0_tx_enc,
    input  logic [WORD_W-1:0] lane_1_tx_enc,
    output logic              lane_0_tx_bit,
    output logic              lane_1_tx_bit,
    output logic              tx_valid,
    output logic              frame_start,
    output logic              ready,
    output logic              overflow
);

    ser_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] frame_len, frame_len_n;
    hold_ctl_t        hold, hold_n;
    logic             overflow_n;
    logic             tx_valid_n;
    logic             frame_start_n;
    logic             ld_word, ld_hold, do_shift, cap, go_idle;
    logic             word_ok;
    logic             last_bit;
    logic             flush;
    logic [LEN_W-1:0] word_len;

    assign flush    = !enable;
    assign word_ok  = word_valid && gen_supported(gen_speed);
    assign word_len = frame_len_of(gen_speed);
    assign last_bit = (state == SHIFT) && (cnt == frame_len);

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        frame_len_n   = frame_len;
        hold_n        = hold;
        overflow_n    = overflow;
        tx_valid_n    = tx_valid;
        frame_start_n = 1'b0;
        ld_word       = 1'b0;
        ld_hold       = 1'b0;
        do_shift      = 1'b0;
        cap           = 1'b0;
        go_idle       = 1'b0;
        case (state)
            IDLE: begin
                if (word_ok) begin
                    ld_word       = 1'b1;
                    cnt_n         = CNT_W'(1);
                    frame_len_n   = CNT_W'(word_len);
                    tx_valid_n    = 1'b1;
                    frame_start_n = 1'b1;
                    state_n       = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (hold.full) begin
                        ld_hold       = 1'b1;
                        cnt_n         = CNT_W'(1);
                        frame_len_n   = CNT_W'(hold.len);
                        frame_start_n = 1'b1;
                        if (word_ok) begin
                            cap         = 1'b1;
                            hold_n.len  = word_len;
                        end else begin
                            hold_n.full = 1'b0;
                        end
                    end else if (word_ok) begin
                        ld_word       = 1'b1;
                        cnt_n         = CNT_W'(1);
                        frame_len_n   = CNT_W'(word_len);
                        frame_start_n = 1'b1;
                    end else begin
                        go_idle    = 1'b1;
                        cnt_n      = '0;
                        tx_valid_n = 1'b0;
                        state_n    = IDLE;
                    end
                end else begin
                    do_shift = 1'b1;
                    cnt_n    = cnt + CNT_W'(1);
                    if (word_ok) begin
                        if (!hold.full) begin
                            cap         = 1'b1;
                            hold_n.full = 1'b1;
                            hold_n.len  = word_len;
                        end else begin
                            overflow_n = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            frame_len   <= '0;
            hold        <= '0;
            overflow    <= 1'b0;
            tx_valid    <= 1'b0;
            frame_start <= 1'b0;
            ready       <= 1'b1;
        end else if (flush) begin
            // Overflow survives a flush so software can still see the loss.
            state       <= IDLE;
            cnt         <= '0;
            frame_len   <= '0;
            hold        <= '0;
            tx_valid    <= 1'b0;
            frame_start <= 1'b0;
            ready       <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            frame_len   <= frame_len_n;
            hold        <= hold_n;
            overflow    <= overflow_n;
            tx_valid    <= tx_valid_n;
            frame_start <= frame_start_n;
            ready       <= !hold_n.full;
        end
    end

    lane_shift_unit #(
        .WORD_W (WORD_W)
`ifdef SER_MSB_FIRST_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) u_lane_0 (
        .enc_clk   (enc_clk),
        .rst       (rst),
        .clr       (flush),
        .load_word (ld_word),
        .load_hold (ld_hold),
        .shift     (do_shift),
        .capture   (cap),
        .go_idle   (go_idle),
`ifdef SER_MSB_FIRST_EN
        .load_len  (frame_len_n),
        .cur_len   (frame_len),
`endif
        .word      (lane_0_tx_enc),
        .tx_bit    (lane_0_tx_bit)
    );

    lane_shift_unit #(
        .WORD_W (WORD_W)
`ifdef SER_MSB_FIRST_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) u_lane_1 (
        .enc_clk   (enc_clk),
        .rst       (rst),
        .clr       (flush),
        .load_word (ld_word),
        .load_hold (ld_hold),
        .shift     (do_shift),
        .capture   (cap),
        .go_idle   (go_idle),
`ifdef SER_MSB_FIRST_EN
        .load_len  (frame_len_n),
        .cur_len   (frame_len),
`endif
        .word      (lane_1_tx_enc),
        .tx_bit    (lane_1_tx_bit)
    );

endmodule

// File: tb/tb_lane_tx_serializer.sv
// Directed bench for lane_tx_serializer in its default LSB-first build.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
module tb_lane_tx_serializer;

    logic         enc_clk;
    logic         rst;
    logic         enable;
    logic [1:0]   gen_speed;
    logic         word_valid;
    logic [131:0] lane_0_tx_enc;
    logic [131:0] lane_1_tx_enc;
    logic         lane_0_tx_bit;
    logic         lane_1_tx_bit;
    logic         tx_valid;
    logic         frame_start;
    logic         ready;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   g4_l0_bits;
    logic [7:0]   g4_l1_bits;
    logic [65:0]  wa0, wa1, wb0, wb1;
    logic [131:0] c0, c1, d0, d1;
    logic         e0, e1;

    lane_tx_serializer #(.WORD_W(132), .CNT_W(8)) dut (
        .enc_clk       (enc_clk),
        .rst           (rst),
        .enable        (enable),
        .gen_speed     (gen_speed),
        .word_valid    (word_valid),
        .lane_0_tx_enc (lane_0_tx_enc),
        .lane_1_tx_enc (lane_1_tx_enc),
        .lane_0_tx_bit (lane_0_tx_bit),
        .lane_1_tx_bit (lane_1_tx_bit),
        .tx_valid      (tx_valid),
        .frame_start   (frame_start),
        .ready         (ready),
        .overflow      (overflow)
    );

    initial enc_clk = 1'b0;
    always #5 enc_clk = ~enc_clk;

    task automatic tick;
        @(posedge enc_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_ovf);
        chk({tag, "_txv"}, 32'(tx_valid), 32'd0);
        chk({tag, "_l0"},  32'(lane_0_tx_bit), 32'd0);
        chk({tag, "_l1"},  32'(lane_1_tx_bit), 32'd0);
        chk({tag, "_fs"},  32'(frame_start), 32'd0);
        chk({tag, "_rdy"}, 32'(ready), 32'd1);
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; gen_speed = 2'd0; word_valid = 1'b0;
        lane_0_tx_enc = '0; lane_1_tx_enc = '0;
        // LSB-first images of 8'hA5 and 8'h3C, bit i = cycle i
        g4_l0_bits = 8'b1010_0101;
        g4_l1_bits = 8'b0011_1100;
        wa0 = 66'h2_1234_5678_9ABC_DEF1; wa1 = 66'h1_F0E1_D2C3_B4A5_9687;
        wb0 = 66'h3_0F0F_00FF_5A5A_C3C2; wb1 = 66'h0_8421_1248_7E7E_0003;
        c0  = 132'h9_0123_4567_89AB_CDEF_FEDC_BA98_7654_3211;
        c1  = 132'h6_FEDC_BA98_7654_3210_0123_4567_89AB_CDE5;
        d0  = 132'hC_0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7875;
        d1  = 132'h3_F0F0_E1E1_D2D2_C3C3_B4B4_A5A5_9696_8789;

        // reset state
        tick; tick;
        chk_idle("rst", 1'b0);
        rst = 1'b1; enable = 1'b1;
        tick; tick;
        chk_idle("post_rst", 1'b0);

        // Gen4 single frame
        gen_speed = 2'd0;
        lane_0_tx_enc = {124'hFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 8'hA5};
        lane_1_tx_enc = {124'h0, 8'h3C};
        word_valid = 1'b1;
        tick;
        word_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("g4_l0",  32'(lane_0_tx_bit), 32'(g4_l0_bits[i]));
            chk("g4_l1",  32'(lane_1_tx_bit), 32'(g4_l1_bits[i]));
            chk("g4_txv", 32'(tx_valid), 32'd1);
            chk("g4_fs",  32'(frame_start), 32'(i == 0));
            chk("g4_rdy", 32'(ready), 32'd1);
            tick;
        end
        chk_idle("g4_end", 1'b0);
        tick;
        chk_idle("g4_quiet", 1'b0);

        // reserved speed: word dropped silently
        gen_speed = 2'd3; word_valid = 1'b1;
        tick;
        word_valid = 1'b0;
        chk_idle("g_rsvd", 1'b0);

        // Gen2 back-to-back, second word strobed at cycle index 10
        gen_speed = 2'd2;
        lane_0_tx_enc = {66'h3_FFFF_FFFF_FFFF_FFFF, wa0};
        lane_1_tx_enc = {66'h2_AAAA_AAAA_AAAA_AAAA, wa1};
        word_valid = 1'b1;
        tick;
        for (int i = 0; i < 132; i++) begin
            e0 = (i < 66) ? wa0[i] : wb0[i-66];
            e1 = (i < 66) ? wa1[i] : wb1[i-66];
            chk("g2_l0",  32'(lane_0_tx_bit), 32'(e0));
            chk("g2_l1",  32'(lane_1_tx_bit), 32'(e1));
            chk("g2_txv", 32'(tx_valid), 32'd1);
            chk("g2_fs",  32'(frame_start), 32'(i == 0 || i == 66));
            chk("g2_rdy", 32'(ready), 32'(!(i >= 11 && i <= 65)));
            if (i == 10) begin
                word_valid = 1'b1;
                lane_0_tx_enc = {66'h1_5555_5555_5555_5555, wb0};
                lane_1_tx_enc = {66'h3_FFFF_0000_FFFF_0000, wb1};
            end else begin
                word_valid = 1'b0;
            end
            tick;
        end
        chk_idle("g2_end", 1'b0);

        // Gen3 boundary strobe on the last-bit cycle plus mid-frame speed change
        gen_speed = 2'd1;
        lane_0_tx_enc = c0; lane_1_tx_enc = c1;
        word_valid = 1'b1;
        tick;
        for (int i = 0; i < 264; i++) begin
            e0 = (i < 132) ? c0[i] : d0[i-132];
            e1 = (i < 132) ? c1[i] : d1[i-132];
            chk("g3_l0",  32'(lane_0_tx_bit), 32'(e0));
            chk("g3_l1",  32'(lane_1_tx_bit), 32'(e1));
            chk("g3_txv", 32'(tx_valid), 32'd1);
            chk("g3_fs",  32'(frame_start), 32'(i == 0 || i == 132));
            chk("g3_rdy", 32'(ready), 32'd1);
            word_valid = 1'b0;
            if (i == 50) gen_speed = 2'd2;
            if (i == 130) begin
                gen_speed = 2'd1;
                lane_0_tx_enc = d0; lane_1_tx_enc = d1;
            end
            if (i == 131) word_valid = 1'b1;
            tick;
        end
        chk_idle("g3_end", 1'b0);

        // Overflow: hold filled at index 5, third word at cnt = 40 dropped
        gen_speed = 2'd2;
        lane_0_tx_enc = {66'h0, wa0}; lane_1_tx_enc = {66'h0, wa1};
        word_valid = 1'b1;
        tick;
        for (int i = 0; i < 132; i++) begin
            e0 = (i < 66) ? wa0[i] : wb0[i-66];
            e1 = (i < 66) ? wa1[i] : wb1[i-66];
            chk("ov_l0",  32'(lane_0_tx_bit), 32'(e0));
            chk("ov_l1",  32'(lane_1_tx_bit), 32'(e1));
            chk("ov_fs",  32'(frame_start), 32'(i == 0 || i == 66));
            chk("ov_rdy", 32'(ready), 32'(!(i >= 6 && i <= 65)));
            chk("ov_ovf", 32'(overflow), 32'(i >= 40));
            word_valid = 1'b0;
            if (i == 5) begin
                word_valid = 1'b1;
                lane_0_tx_enc = {66'h0, wb0}; lane_1_tx_enc = {66'h0, wb1};
            end
            if (i == 39) begin
                word_valid = 1'b1;
                lane_0_tx_enc = '1; lane_1_tx_enc = '1;
            end
            tick;
        end
        chk_idle("ov_end", 1'b1);

        // Mid-frame disable at cnt = 30
        gen_speed = 2'd1;
        lane_0_tx_enc = c0; lane_1_tx_enc = c1;
        word_valid = 1'b1;
        tick;
        word_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            chk("dis_txv", 32'(tx_valid), 32'd1);
            chk("dis_l0",  32'(lane_0_tx_bit), 32'(c0[i]));
            if (i == 29) enable = 1'b0;
            tick;
        end
        chk_idle("dis_off", 1'b1);
        enable = 1'b1;
        tick; tick; tick;
        chk_idle("dis_on", 1'b1);

        // Asynchronous reset mid-frame clears overflow too
        lane_0_tx_enc = d0; lane_1_tx_enc = d1;
        word_valid = 1'b1;
        tick;
        word_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        chk("ar_txv_pre", 32'(tx_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk_idle("ar_async", 1'b0);
        tick;
        rst = 1'b1;
        tick; tick; tick;
        chk_idle("ar_quiet", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
